// File: rtl/memory_load_unit_pkg.sv
// Shared definitions for the memory load unit: access-size and FSM state
// encodings, the datapath width and small request-decoding helpers.
package memory_load_unit_pkg;

  localparam int DATA_W = 32;

  // Access size as presented on the request interface
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Load sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // A request is rejected for the reserved size or a misaligned half/word.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lsb[0];
      SZ_WORD: bad = (addr_lsb != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Index of the last byte lane read for a given size (N-1).
  function automatic logic [1:0] last_lane(input logic [1:0] size);
    logic [1:0] lane;
    lane = 2'd0;
    case (size)
      SZ_HALF: lane = 2'd1;
      SZ_WORD: lane = 2'd3;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/memory_load_unit_if.sv
// Request/response handshake plus byte-wide memory read port of the load unit.
interface memory_load_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic                  sign_ext;
  logic                  busy;
  logic                  done;
  logic [31:0]           data_out;
  logic                  misaligned;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_rd_data;

  // The load unit itself
  modport slave (
    input  start, addr, size, sign_ext, mem_rd_data,
    output busy, done, data_out, misaligned, mem_rd_en, mem_addr
  );

  // Requester / memory side
  modport master (
    output start, addr, size, sign_ext, mem_rd_data,
    input  busy, done, data_out, misaligned, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/memory_load_unit_load_extend.sv
// Combinational sign/zero extension of an assembled little-endian load word.
// Also used by the register write-back mux, so it stays free of state.
module memory_load_unit_load_extend
  import memory_load_unit_pkg::*;
(
  input  logic [DATA_W-1:0] word_in,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] word_out
);

  // Fill the upper bits from the top bit of the loaded quantity or with zero
  always_comb begin
    word_out = '0;
    case (size)
      SZ_BYTE: word_out = {{24{sign_ext & word_in[7]}}, word_in[7:0]};
      SZ_HALF: word_out = {{16{sign_ext & word_in[15]}}, word_in[15:0]};
      SZ_WORD: word_out = word_in;
      default: word_out = '0;
    endcase
  end

endmodule

// File: rtl/memory_load_unit.sv
// Multi-cycle load sequencer: reads 1, 2 or 4 bytes one at a time from the
// byte-wide data memory, assembles them little-endian, extends the result to
// 32 bits and reports it with a start/busy/done handshake.
module memory_load_unit
  import memory_load_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1   // 1..3 cycles from read strobe to data
)(
  input  logic              clock,
  input  logic              reset,   // asynchronous, active-low
  memory_load_unit_if.slave bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            size_q, size_d;
  logic                  sx_q, sx_d;
  logic [1:0]            k_q, k_d;
  logic [1:0]            lat_q, lat_d;
  logic [DATA_W-1:0]     asm_q, asm_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [DATA_W-1:0]     asm_capture;
  logic [DATA_W-1:0]     ext_word;
  logic [1:0]            k_inc;

  // Assembly word with the incoming byte dropped into lane k
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign asm_capture[8*gi +: 8] = (k_q == 2'(gi)) ? bus.mem_rd_data : asm_q[8*gi +: 8];
  end

  assign k_inc = k_q + 2'd1;

  memory_load_unit_load_extend u_load_extend (
    .word_in  (asm_capture),
    .size     (size_q),
    .sign_ext (sx_q),
    .word_out (ext_word)
  );

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      size_q     <= 2'b00;
      sx_q       <= 1'b0;
      k_q        <= 2'd0;
      lat_q      <= 2'd0;
      asm_q      <= '0;
      data_out_q <= '0;
      mis_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      sx_q       <= sx_d;
      k_q        <= k_d;
      lat_q      <= lat_d;
      asm_q      <= asm_d;
      data_out_q <= data_out_d;
      mis_q      <= mis_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next-state and datapath update; requests are only taken in IDLE or DONE
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    sx_d       = sx_q;
    k_d        = k_q;
    lat_d      = lat_q;
    asm_d      = asm_q;
    data_out_d = data_out_q;
    mis_d      = mis_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        mis_d   = 1'b0;
        state_d = ST_IDLE;
        if (bus.start) begin
          base_d = bus.addr;
          size_d = bus.size;
          sx_d   = bus.sign_ext;
          k_d    = 2'd0;
          asm_d  = '0;
          if (is_illegal(bus.size, bus.addr[1:0])) begin
            // Rejected without touching memory
            state_d    = ST_DONE;
            mis_d      = 1'b1;
            data_out_d = '0;
          end else begin
            state_d    = ST_ISSUE;
            mem_addr_d = bus.addr;
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = 2'(MEM_LATENCY);
      end

      ST_WAIT: begin
        lat_d = lat_q - 2'd1;
        if (lat_q == 2'd1) begin
          asm_d = asm_capture;
          if (k_q == last_lane(size_q)) begin
            state_d    = ST_DONE;
            data_out_d = ext_word;
          end else begin
            k_d        = k_inc;
            mem_addr_d = base_q + ADDR_WIDTH'(k_inc);
            state_d    = ST_ISSUE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.misaligned = (state_q == ST_DONE) && mis_q;
  assign bus.mem_rd_en  = (state_q == ST_ISSUE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_memory_load_unit.sv
// Directed bench for memory_load_unit with MEM_LATENCY=1.
module tb_memory_load_unit;
  import memory_load_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memory_load_unit_if #(.ADDR_WIDTH(32)) bus ();

  memory_load_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h21;
      32'h101: return 8'h43;
      32'h102: return 8'h65;
      32'h103: return 8'h87;
      default: return 8'hC3;
    endcase
  endfunction

  // Memory: data valid the cycle after the strobe, filler byte otherwise
  always @(posedge clock) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_byte(bus.mem_addr);
    else               bus.mem_rd_data <= 8'hEE;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sx;
    int          poke;      // cycle in which a stray start is raised (0 = none)
    logic [31:0] exp_data;
    int          exp_cyc;
    logic        exp_mis;
    int          exp_nrd;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] rd_log[8];
  int          n_rd;
  int          done_cyc;
  logic [31:0] dout;
  logic        mis;

  // One load: start sampled at edge 0, cycle c observed at the c-th following negedge
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sx, input int poke);
    @(negedge clock);
    bus.start = 1'b1; bus.addr = a; bus.size = sz; bus.sign_ext = sx;
    done_cyc = -1; n_rd = 0; dout = '0; mis = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (bus.mem_rd_en) begin
        if (n_rd < 8) rd_log[n_rd] = bus.mem_addr;
        n_rd++;
      end
      if (bus.done) begin
        done_cyc = c; dout = bus.data_out; mis = bus.misaligned;
        bus.start = 1'b0;
        break;
      end
      if (c == poke) begin
        bus.start = 1'b1; bus.addr = 32'h200; bus.size = SZ_BYTE;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  int first_done, second_done;

  initial begin
    bus.start = 1'b0; bus.addr = '0; bus.size = 2'b00; bus.sign_ext = 1'b0;

    vecs[0] = '{32'h100,      SZ_WORD, 1'b1, 0, 32'h87654321, 9, 1'b0, 4};
    vecs[1] = '{32'h103,      SZ_BYTE, 1'b1, 0, 32'hFFFFFF87, 3, 1'b0, 1};
    vecs[2] = '{32'h103,      SZ_BYTE, 1'b0, 0, 32'h00000087, 3, 1'b0, 1};
    vecs[3] = '{32'h102,      SZ_HALF, 1'b1, 0, 32'hFFFF8765, 5, 1'b0, 2};
    vecs[4] = '{32'h100,      SZ_HALF, 1'b0, 0, 32'h00004321, 5, 1'b0, 2};
    vecs[5] = '{32'h101,      SZ_WORD, 1'b1, 0, 32'h00000000, 1, 1'b1, 0};
    vecs[6] = '{32'hFFFFFFFF, SZ_BYTE, 1'b1, 0, 32'hFFFFFFC3, 3, 1'b0, 1};
    vecs[7] = '{32'h100,      SZ_RSVD, 1'b0, 0, 32'h00000000, 1, 1'b1, 0};
    vecs[8] = '{32'h100,      SZ_WORD, 1'b0, 3, 32'h87654321, 9, 1'b0, 4};
    vecs[9] = '{32'h101,      SZ_HALF, 1'b0, 0, 32'h00000000, 1, 1'b1, 0};

    // Power-on reset
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check32("reset_busy",     32'(bus.busy),      32'h0);
    check32("reset_done",     32'(bus.done),      32'h0);
    check32("reset_mem_rd",   32'(bus.mem_rd_en), 32'h0);
    check32("reset_mem_addr", bus.mem_addr,       32'h0);
    check32("reset_data_out", bus.data_out,       32'h0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_load(vecs[i].addr, vecs[i].size, vecs[i].sx, vecs[i].poke);
      $display("vec %0d: addr=0x%08h size=%0d sx=%0b -> data=0x%08h done_cyc=%0d mis=%0b reads=%0d",
               i, vecs[i].addr, vecs[i].size, vecs[i].sx, dout, done_cyc, mis, n_rd);
      check32($sformatf("v%0d_done_cycle", i), 32'(done_cyc), 32'(vecs[i].exp_cyc));
      check32($sformatf("v%0d_data", i),       dout,          vecs[i].exp_data);
      check32($sformatf("v%0d_misaligned", i), 32'(mis),      32'(vecs[i].exp_mis));
      check32($sformatf("v%0d_reads", i),      32'(n_rd),     32'(vecs[i].exp_nrd));
      for (int j = 0; j < vecs[i].exp_nrd && j < n_rd; j++)
        check32($sformatf("v%0d_rd_addr%0d", i, j), rd_log[j], vecs[i].addr + 32'(j));
      @(negedge clock);
      check32($sformatf("v%0d_done_after", i), 32'(bus.done),   32'h0);
      check32($sformatf("v%0d_data_hold", i),  bus.data_out,    vecs[i].exp_data);
      check32($sformatf("v%0d_idle_busy", i),  32'(bus.busy),   32'h0);
    end

    // Reset in cycle 4 of a word load: outputs clear at once, no done
    @(negedge clock);
    bus.start = 1'b1; bus.addr = 32'h100; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check32("rst_mid_busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    $display("async reset mid-load: busy=%0b done=%0b rd_en=%0b mem_addr=0x%08h data=0x%08h",
             bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.data_out);
    check32("rst_mid_busy",     32'(bus.busy),       32'h0);
    check32("rst_mid_done",     32'(bus.done),       32'h0);
    check32("rst_mid_mis",      32'(bus.misaligned), 32'h0);
    check32("rst_mid_rd_en",    32'(bus.mem_rd_en),  32'h0);
    check32("rst_mid_mem_addr", bus.mem_addr,        32'h0);
    check32("rst_mid_data_out", bus.data_out,        32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check32("rst_hold_done", 32'(bus.done), 32'h0);
    end
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check32("post_rst_no_done", 32'(bus.done), 32'h0);
    end
    run_load(32'h100, SZ_BYTE, 1'b0, 0);
    $display("post-reset byte load: data=0x%08h done_cyc=%0d", dout, done_cyc);
    check32("post_rst_data",  dout,            32'h00000021);
    check32("post_rst_cycle", 32'(done_cyc),   32'd3);

    // Back-to-back: start held high across the DONE cycle
    @(negedge clock);
    @(negedge clock);
    bus.start = 1'b1; bus.addr = 32'h100; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
    first_done = -1; second_done = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (first_done > 0 && c == first_done + 1) begin
        check32("b2b_issue_rd_en", 32'(bus.mem_rd_en), 32'h1);
        check32("b2b_issue_addr",  bus.mem_addr,       32'h101);
      end
      if (bus.done) begin
        if (first_done < 0) begin
          first_done = c;
          $display("b2b first: cycle=%0d data=0x%08h", c, bus.data_out);
          check32("b2b_first_data", bus.data_out, 32'h87654321);
          bus.addr = 32'h101; bus.size = SZ_BYTE;
        end else begin
          second_done = c;
          $display("b2b second: cycle=%0d data=0x%08h", c, bus.data_out);
          check32("b2b_second_data", bus.data_out, 32'h00000043);
          break;
        end
      end else if (first_done > 0) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check32("b2b_first_cycle",  32'(first_done),  32'd9);
    check32("b2b_second_cycle", 32'(second_done), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_load_unit.md
Name: memory_load_unit

Overview:
Multi-cycle load sequencer for the microprocessor datapath. It reads a byte, halfword or word from the byte-wide data memory, one byte per access, and assembles the bytes little-endian. It sign- or zero-extends the result to 32 bits and hands it to the register write-back path with a start/busy/done handshake. It is the read-side counterpart of the datapath's 32-bit storage/write path.

Parameters:
ADDR_WIDTH, 32, width of the base address and the memory address.
MEM_LATENCY, 1, cycles from the mem_rd_en cycle to the cycle in which mem_rd_data is valid; legal range 1..3.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  request a load; sampled only when not busy
addr  in  ADDR_WIDTH  base byte address
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sign_ext  in  1  1 = sign-extend, 0 = zero-extend
busy  out  1  high while a memory sequence is in progress
done  out  1  one-cycle pulse, result valid
data_out  out  32  extended load result
misaligned  out  1  one-cycle pulse coincident with done on an illegal request
mem_rd_en  out  1  byte read strobe
mem_addr  out  ADDR_WIDTH  byte address of the current access
mem_rd_data  in  8  read byte from memory

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - busy, done, misaligned and mem_rd_en go to 0 immediately.
  - mem_addr=0, data_out=0.
  - Byte counter, latency counter and assembly register are cleared.
  - An in-flight load is abandoned with no done.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE/DONE + start=1:
  - Latch addr, size and sign_ext.
  - Number of bytes N = 1/2/4.
  - A request is illegal if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠0.
  - Illegal request -> next state DONE, no memory access, data_out=0, misaligned=1.
  - Legal request -> next state ISSUE, k=0.
- ISSUE, one cycle:
  - mem_rd_en=1, mem_addr=base+k.
  - Next state WAIT with latency count = MEM_LATENCY.
- WAIT:
  - mem_rd_en=0.
  - Decrement the latency count each cycle.
  - In the cycle where the count reaches its last value, capture mem_rd_data into byte lane k (bits 8k+7:8k).
  - If k<N-1: k++, next state ISSUE. Otherwise next state DONE.
- DONE, one cycle:
  - done=1.
  - data_out is updated with the extended result.
  - Byte loads: bits 31:8 are filled with b[7] (sign) or 0 (zero).
  - Halfword loads: bits 31:16 are filled with bit 15 (sign) or 0 (zero).
  - Word loads pass through unchanged.
- Latency: done is high in cycle N*(1+MEM_LATENCY)+1 after the start-sampling edge. Word with MEM_LATENCY=1 gives cycle 9.
- busy=1 in ISSUE and WAIT only. start is ignored while busy.
- DONE + start=1: the new load is accepted back-to-back (DONE -> ISSUE) with no idle cycle. Otherwise DONE -> IDLE.
- data_out holds its value between done pulses; it changes only in a DONE cycle.
- mem_addr holds the last issued address when not in ISSUE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH (base 0xFFFFFFFF, byte load is legal).

Decomposition:
- Shared package:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - state encoding localparams;
  - data width constant 32.
- One natural sub-module: load_extend. It is combinational and takes the assembled word, size and sign_ext, producing the 32-bit extended result. It is reused by the write-back mux.

Test Plan:
All tests use MEM_LATENCY=1. The memory model holds 0x100..0x103 = 0x21, 0x43, 0x65, 0x87.
- Word, signed, addr 0x100 -> mem_addr 0x100..0x103 on 4 mem_rd_en pulses; done in cycle 9; data_out=0x87654321; misaligned=0.
- Byte at 0x103 -> sign_ext=1 gives 0xFFFFFF87; sign_ext=0 gives 0x00000087. done in cycle 3 in both cases.
- Half at 0x102, signed -> 0xFFFF8765. Half at 0x100, unsigned -> 0x00004321. done in cycle 5.
- Word at 0x101, or size=11 -> done and misaligned high in cycle 1; data_out=0; mem_rd_en never asserted.
- reset=0 in cycle 4 of a word load -> all outputs 0 asynchronously and no done. After release, a byte load at 0x100 returns 0x00000021.
- start held high through a DONE cycle (word at 0x100, then byte at 0x101) -> second ISSUE in the cycle after done; done pulses in cycles 9 and 12; data_out 0x87654321, then 0x00000043. start asserted mid-load is ignored.
